// File: rtl/seg_scan_bcd.sv
// Binary-to-BCD converter (serial double-dabble) driving a multiplexed
// active-low 7-segment display with leading-zero blanking, decimal points and blink.
module seg_scan_bcd #(
    parameter int unsigned DIGITS      = 6,
    parameter int unsigned VAL_W       = 20,
    parameter int unsigned SCAN_DIV    = 50_000,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [VAL_W-1:0]  value,
    input  logic              load,
    input  logic [DIGITS-1:0] dp_mask,
    input  logic [DIGITS-1:0] blink_mask,
    input  logic              lz_blank,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] seg_sel,
    output logic [7:0]        seg_led
);

    localparam int unsigned BCD_W  = DIGITS * 4;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned BLK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned CNT_W  = $clog2(VAL_W + 1);

    function automatic logic [31:0] pow10(input int unsigned n);
        logic [31:0] r;
        r = 32'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

    localparam logic [31:0] MAX_DEC = pow10(DIGITS) - 32'd1;

    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state;
    logic [VAL_W-1:0]   bin;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   disp;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ovf_pend;

    logic [SCAN_W-1:0]  scan_cnt;
    logic               scan_tick;
    logic [IDX_W-1:0]   idx;
    logic [BLK_W-1:0]   blink_cnt;
    logic               blink_phase;

    logic [DIGITS-1:0]  lz_mask;
    logic               any_nz;
    logic [3:0]         cur_dig;
    logic [7:0]         pat;

    // Double-dabble correction: +3 on every nibble >= 5 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    // Conversion FSM; display and ovf only change when a conversion completes
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            bin      <= '0;
            bcd      <= '0;
            disp     <= '0;
            bit_cnt  <= '0;
            ovf_pend <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin      <= value;
                        ovf_pend <= (32'(value) > MAX_DEC);
                        bcd      <= '0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd     <= {bcd_adj[BCD_W-2:0], bin[VAL_W-1]};
                    bin     <= {bin[VAL_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(VAL_W - 1)) state <= DONE;
                end
                DONE: begin
                    disp  <= bcd;
                    ovf   <= ovf_pend;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign scan_tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    // Digit slot timing and blink phase
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scan_cnt    <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Pattern for the currently selected digit; blink overrides dp, dp survives lz
    always_comb begin
        any_nz  = 1'b0;
        lz_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz     = any_nz | (disp[i*4 +: 4] != 4'd0);
            lz_mask[i] = lz_blank & ~any_nz & (i != 0);
        end
        cur_dig = disp[{idx, 2'b00} +: 4];
        pat     = ovf ? 8'hBF : enc(cur_dig);
        if (lz_mask[idx]) pat = 8'hFF;
        if (dp_mask[idx]) pat[7] = 1'b0;
        if (blink_phase && blink_mask[idx]) pat = 8'hFF;
    end

    // Select and pattern share one register stage so they never disagree
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            seg_sel <= ~DIGITS'(1);
            seg_led <= 8'hFF;
        end else begin
            seg_sel <= ~(DIGITS'(1) << idx);
            seg_led <= pat;
        end
    end

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Directed self-checking bench for seg_scan_bcd with a fast scan rate.
module tb_seg_scan_bcd;

    localparam int unsigned DIGITS = 6;
    localparam int unsigned VAL_W  = 20;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [VAL_W-1:0]  value;
    logic              load;
    logic [DIGITS-1:0] dp_mask;
    logic [DIGITS-1:0] blink_mask;
    logic              lz_blank;
    logic              busy;
    logic              ovf;
    logic [DIGITS-1:0] seg_sel;
    logic [7:0]        seg_led;

    int checks = 0;
    int errors = 0;

    seg_scan_bcd #(
        .DIGITS(DIGITS), .VAL_W(VAL_W), .SCAN_DIV(4), .BLINK_TICKS(2)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .value(value), .load(load),
        .dp_mask(dp_mask), .blink_mask(blink_mask), .lz_blank(lz_blank),
        .busy(busy), .ovf(ovf), .seg_sel(seg_sel), .seg_led(seg_led)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for a fresh display window of digit d and returns its pattern
    task automatic wait_digit(input int d, output logic [7:0] pat);
        logic [DIGITS-1:0] tgt;
        int n;
        tgt = ~(DIGITS'(1) << d);
        n = 0;
        while (seg_sel == tgt && n < 200) begin n++; @(negedge sys_clk); end
        while (seg_sel != tgt && n < 200) begin n++; @(negedge sys_clk); end
        if (n >= 200) check("scan_timeout", 32'd1, 32'd0);
        pat = seg_led;
    endtask

    // Starts a conversion at a negedge; optionally injects a second load at busy cycle inj
    task automatic do_load(input logic [VAL_W-1:0] v, input int inj,
                           input logic [VAL_W-1:0] iv, output int n);
        value = v;
        load  = 1'b1;
        @(negedge sys_clk);
        load = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == inj) begin value = iv; load = 1'b1; end
            @(negedge sys_clk);
            load = 1'b0;
        end
    endtask

    task automatic check_digits(input string tag, input logic [7:0] exp [DIGITS]);
        logic [7:0] p;
        for (int d = 0; d < DIGITS; d++) begin
            wait_digit(d, p);
            check($sformatf("%s_d%0d", tag, d), 32'(p), 32'(exp[d]));
        end
    endtask

    logic [7:0] e [DIGITS];
    logic [7:0] p0, p1;
    int n;

    initial begin
        sys_rst    = 1'b1;
        value      = '0;
        load       = 1'b0;
        dp_mask    = '0;
        blink_mask = '0;
        lz_blank   = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("rst_sel", 32'(seg_sel), 32'h3E);
        check("rst_led", 32'(seg_led), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("first_sel", 32'(seg_sel), 32'h3E);
        check("first_led", 32'(seg_led), 32'hC0);

        do_load(20'd123456, 0, '0, n);
        check("busy_len_123456", 32'(n), 32'd21);
        check("ovf_123456", 32'(ovf), 32'd0);
        e = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        check_digits("v123456", e);

        lz_blank = 1'b1;
        do_load(20'd42, 0, '0, n);
        check("busy_len_42", 32'(n), 32'd21);
        e = '{8'hA4, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_digits("v42_lz", e);

        do_load(20'd0, 0, '0, n);
        e = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_digits("v0_lz", e);

        lz_blank = 1'b0;
        do_load(20'd1_000_000, 0, '0, n);
        check("ovf_set", 32'(ovf), 32'd1);
        e = '{8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
        check_digits("v_ovf", e);

        do_load(20'd7, 0, '0, n);
        check("ovf_clr", 32'(ovf), 32'd0);
        e = '{8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        check_digits("v7", e);

        // Load mid-conversion must neither restart nor replace the value
        do_load(20'd555, 5, 20'd999, n);
        check("busy_len_ignored", 32'(n), 32'd21);
        e = '{8'h92, 8'h92, 8'h92, 8'hC0, 8'hC0, 8'hC0};
        check_digits("v555", e);

        // Load sampled in the DONE cycle must be ignored as well
        @(negedge sys_clk);
        do_load(20'd318, 21, 20'd999, n);
        check("busy_len_318", 32'(n), 32'd21);
        check("done_load_busy", 32'(busy), 32'd0);
        @(negedge sys_clk);
        check("done_load_busy2", 32'(busy), 32'd0);
        e = '{8'h80, 8'hF9, 8'hB0, 8'hC0, 8'hC0, 8'hC0};
        check_digits("v318", e);

        // Reset mid-conversion aborts and clears display
        value = 20'd654321;
        load  = 1'b1;
        @(negedge sys_clk);
        load = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("conv_busy", 32'(busy), 32'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_led", 32'(seg_led), 32'hFF);
        sys_rst = 1'b0;
        repeat (30) @(negedge sys_clk);
        check("abort_idle", 32'(busy), 32'd0);
        e = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        check_digits("v_abort", e);

        // Blink and decimal point
        do_load(20'd6, 0, '0, n);
        blink_mask = 6'b000001;
        dp_mask    = 6'b000100;
        wait_digit(2, p0);
        check("dp_d2", 32'(p0), 32'h40);
        wait_digit(1, p0);
        check("dp_d1", 32'(p0), 32'hC0);
        wait_digit(0, p0);
        check("blink_first_valid", 32'((p0 == 8'h82) || (p0 == 8'hFF)), 32'd1);
        wait_digit(0, p1);
        check("blink_alt1", 32'(p1), (p0 == 8'h82) ? 32'hFF : 32'h82);
        wait_digit(0, p0);
        check("blink_alt2", 32'(p0), (p1 == 8'h82) ? 32'hFF : 32'h82);

        // dp survives leading-zero blanking
        lz_blank = 1'b1;
        wait_digit(2, p0);
        check("dp_lz_d2", 32'(p0), 32'h7F);
        wait_digit(3, p0);
        check("lz_d3", 32'(p0), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_bcd.md
SEG_SCAN_BCD -- requirements
Module: seg_scan_bcd

Interface
REQ-001 Parameter DIGITS, default 6, number of multiplexed digits (legal 1..8).
REQ-002 Parameter VAL_W, default 20, binary input width (legal 4..27).
REQ-003 Parameter SCAN_DIV, default 50_000, sys_clk cycles per digit slot (legal >= 2).
REQ-004 Parameter BLINK_TICKS, default 250, scan ticks per blink half-period (legal >= 1).
REQ-005 sys_clk  in  1  sole clock; all state on rising edge.
REQ-006 sys_rst  in  1  reset, asynchronous, active-high.
REQ-007 value  in  VAL_W  unsigned binary value to display.
REQ-008 load  in  1  single-cycle request to convert and display value.
REQ-009 dp_mask  in  DIGITS  per-digit decimal point enable, bit i = digit i.
REQ-010 blink_mask  in  DIGITS  per-digit blink enable.
REQ-011 lz_blank  in  1  leading-zero blanking enable.
REQ-012 busy  out  1  conversion in progress; load ignored while high.
REQ-013 ovf  out  1  last loaded value exceeded 10^DIGITS-1.
REQ-014 seg_sel  out  DIGITS  digit select, active-low one-hot; bit 0 = least significant digit.
REQ-015 seg_led  out  8  segments, active-low; bit 7 = decimal point, bits 6..0 = g..a.

Function
REQ-016 Conversion FSM SHALL have states IDLE, CONV, DONE; IDLE->CONV on load, CONV->DONE after exactly VAL_W shift cycles, DONE->IDLE unconditionally.
REQ-017 On load in IDLE the block SHALL capture value and ovf condition (value > 10^DIGITS-1), and clear the BCD shift register.
REQ-018 CONV SHALL perform one double-dabble step per cycle: add 3 to every BCD nibble >= 5, then shift left one bit, MSB of binary first.
REQ-019 busy SHALL be high from the cycle after load through the DONE cycle (VAL_W+1 cycles); new digits and ovf SHALL be visible in the display register from cycle VAL_W+2 after load.
REQ-020 load while busy, including the DONE cycle, SHALL be ignored with no side effect.
REQ-021 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; at terminal count digit index SHALL advance, wrapping DIGITS-1 -> 0.
REQ-022 seg_sel and seg_led SHALL be registered on the same edge so the pattern always matches the selected digit.
REQ-023 Digit encoding SHALL be 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex, bit 7 = 1).
REQ-024 When ovf=1 every digit SHALL show 0xBF ('-'), dp and lz rules still applied.
REQ-025 When lz_blank=1 digits above the highest nonzero digit SHALL show 0xFF; digit 0 SHALL never be lz-blanked.
REQ-026 Blink phase SHALL toggle every BLINK_TICKS scan ticks; in phase 1 a digit with blink_mask set SHALL show 0xFF including dp, seg_sel unchanged.
REQ-027 dp_mask[i]=1 SHALL clear bit 7 of digit i's pattern unless blink-blanked; dp SHALL apply to lz-blanked digits (pattern 0x7F).
REQ-028 dp_mask, blink_mask and lz_blank SHALL take effect on the next digit update without reconversion.

Reset
REQ-029 While sys_rst high: FSM IDLE, busy=0, ovf=0, display digits all 0, scan and blink counters 0, blink phase 0, index 0.
REQ-030 Reset values: seg_sel = all ones except bit 0 low, seg_led = 0xFF.
REQ-031 Reset during CONV SHALL abort conversion; display SHALL return to zeros.

Verification
REQ-032 Params DIGITS=6, VAL_W=20, SCAN_DIV=4, BLINK_TICKS=2; reset -> seg_sel=111110, seg_led=FF, busy=0; first digit update after release -> digit 0 = C0.
REQ-033 value=123456, load -> busy high 21 cycles; digits 5..0 = F9,A4,B0,99,92,82.
REQ-034 value=42, lz_blank=1 -> digits 5..2 = FF, digit 1 = 99, digit 0 = A4; value=0 -> digit 0 = C0, others FF.
REQ-035 value=1_000_000 -> ovf=1, all digits BF; subsequent value=7 -> ovf=0, digit 0 = F8.
REQ-036 load pulse during busy -> ignored, display keeps first value; sys_rst asserted mid-CONV -> busy=0, digits zero.
REQ-037 value=6, blink_mask=000001, dp_mask=000100 -> digit 0 alternates 82/FF every 2 scan ticks; digit 2 = 40 (lz_blank=0).
